bcd_dabble_converter: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one bit per clock. It generalises the fixed 5-bit two-digit combinational converter to any input width and digit count. It adds valid/ready handshakes on both sides and a leading-zero mask for display drivers. It sits between arithmetic/counter logic and 7-segment decode blocks.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bcd_dabble_converter.sv | 90 +++++++++
 tb/tb_bcd_dabble_converter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type, BCD digit width and the digit-count sizing function for the double-dabble converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_DIGIT_W = 4;
  function automatic int min_digits(input int in_w);
    longint unsigned v;
    int n;
    v = (in_w >= 64) ? '1 : ((64'd1 << in_w) - 64'd1);
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: add-3 corrector for one BCD digit (d_in 4b -> d_out 4b), digits >= 5 get +3 so the following shift carries correctly
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_in,
  output logic [BCD_DIGIT_W-1:0] d_out
);
  always_comb d_out = (d_in >= BCD_DIGIT_W'(5)) ? d_in + BCD_DIGIT_W'(3) : d_in;
endmodule

// File: rtl/bcd_dabble_converter.sv
// bcd_dabble_converter: serial double-dabble binary->BCD; IN/IN_VALID/IN_READY in, BCD/NZ_MASK/OUT_VALID/OUT_READY out, BUSY while shifting
module bcd_dabble_converter
  import bcd_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = $clog2(IN_W + 1)
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [IN_W-1:0]               IN,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD,
  output logic [DIGITS-1:0]             NZ_MASK,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic                          BUSY
);
  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int SW = BW + IN_W;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     sh_q, sh_d;
  logic [BW-1:0]     bcd_q, bcd_d, adj;
  logic [DIGITS-1:0] nz_q, nz_d, nz_c;
  logic              seen;
  if (DIGITS < min_digits(IN_W)) begin : g_chk
    $error("bcd_dabble_converter: DIGITS too small to hold 2^IN_W-1");
  end
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_in (sh_q[IN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .d_out(adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end
  always_comb begin
    seen = 1'b0;
    nz_c = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (|sh_q[IN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]);
      nz_c[i] = seen;
    end
    nz_c[0] = 1'b1;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    nz_d    = nz_q;
    case (state_q)
      IDLE: if (IN_VALID) begin
        sh_d    = {{BW{1'b0}}, IN};
        cnt_d   = CNT_W'(IN_W);
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q != '0) begin
        sh_d  = {adj, sh_q[IN_W-1:0]} << 1;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        bcd_d   = sh_q[SW-1:IN_W];
        nz_d    = nz_c;
        state_d = DONE;
      end
      DONE: state_d = OUT_READY ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      nz_q    <= DIGITS'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      nz_q    <= nz_d;
    end
  end
  assign IN_READY  = state_q == IDLE;
  assign BUSY      = state_q == SHIFT;
  assign OUT_VALID = state_q == DONE;
  assign BCD       = bcd_q;
  assign NZ_MASK   = nz_q;
endmodule

// File: tb/tb_bcd_dabble_converter.sv
// tb_bcd_dabble_converter: directed bench with a transaction-level model for three converter configurations
module tb_bcd_dabble_converter;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic [7:0]  a_in = 0;
  logic        a_valid = 0, a_ordy = 0, a_ir, a_ov, a_busy;
  logic [11:0] a_bcd;
  logic [2:0]  a_nz;
  logic [4:0]  b_in = 0;
  logic        b_valid = 0, b_ordy = 0, b_ir, b_ov, b_busy;
  logic [7:0]  b_bcd;
  logic [1:0]  b_nz;
  logic [15:0] c_in = 0;
  logic        c_valid = 0, c_ordy = 0, c_ir, c_ov, c_busy;
  logic [19:0] c_bcd;
  logic [4:0]  c_nz;
  bcd_dabble_converter #(.IN_W(8), .DIGITS(3)) u_a (
    .CLK(clk), .RST_N(rst_n), .IN(a_in), .IN_VALID(a_valid), .IN_READY(a_ir), .BCD(a_bcd),
    .NZ_MASK(a_nz), .OUT_VALID(a_ov), .OUT_READY(a_ordy), .BUSY(a_busy));
  bcd_dabble_converter #(.IN_W(5), .DIGITS(2)) u_b (
    .CLK(clk), .RST_N(rst_n), .IN(b_in), .IN_VALID(b_valid), .IN_READY(b_ir), .BCD(b_bcd),
    .NZ_MASK(b_nz), .OUT_VALID(b_ov), .OUT_READY(b_ordy), .BUSY(b_busy));
  bcd_dabble_converter #(.IN_W(16), .DIGITS(5)) u_c (
    .CLK(clk), .RST_N(rst_n), .IN(c_in), .IN_VALID(c_valid), .IN_READY(c_ir), .BCD(c_bcd),
    .NZ_MASK(c_nz), .OUT_VALID(c_ov), .OUT_READY(c_ordy), .BUSY(c_busy));
  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [19:0] to_bcd(input longint unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic logic [4:0] nz_of(input longint unsigned v);
    logic [4:0] m;
    longint unsigned p;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      m[i] = (i == 0) || (v >= p);
      p = p * 10;
    end
    return m;
  endfunction
  int          m_st = 0;
  int          m_left = 0;
  int          m_val = 0;
  logic [19:0] m_tmp;
  logic [4:0]  m_ntmp;
  logic [11:0] m_bcd = 0;
  logic [2:0]  m_nz = 3'b001;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_left = 0; m_bcd = 0; m_nz = 3'b001;
    end else if (m_st == 0) begin
      if (a_valid) begin m_val = int'(a_in); m_left = 9; m_st = 1; end
    end else if (m_st == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_st = 2;
        m_tmp = to_bcd(longint'(m_val));
        m_ntmp = nz_of(longint'(m_val));
        m_bcd = m_tmp[11:0];
        m_nz = m_ntmp[2:0];
      end
    end else if (a_ordy) m_st = 0;
  end
  always @(negedge clk) begin
    chk("a_flags", 64'({a_ir, a_busy, a_ov}), 64'({m_st == 0, m_st == 1, m_st == 2}));
    chk("a_bcd_model", 64'(a_bcd), 64'(m_bcd));
    chk("a_nz_model", 64'(a_nz), 64'(m_nz));
  end
  task automatic step;
    @(posedge clk); #2;
  endtask
  task automatic run_a(input int v, input logic [11:0] eb, input logic [2:0] en);
    int n = 0;
    a_in = 8'(v); a_valid = 1; step(); a_valid = 0;
    while (!a_ov && n < 50) begin step(); n++; end
    chk("a_latency", 64'(n), 64'(9));
    chk("a_bcd", 64'(a_bcd), 64'(eb));
    chk("a_nz", 64'(a_nz), 64'(en));
    a_ordy = 1; step(); a_ordy = 0;
  endtask
  task automatic conv_b(input int v, input logic [7:0] eb, input logic [1:0] en);
    int n = 0;
    b_in = 5'(v); b_valid = 1; step(); b_valid = 0;
    while (!b_ov && n < 50) begin step(); n++; end
    chk("b_latency", 64'(n), 64'(6));
    chk("b_bcd", 64'(b_bcd), 64'(eb));
    chk("b_nz", 64'(b_nz), 64'(en));
    b_ordy = 1; step(); b_ordy = 0;
  endtask
  task automatic conv_c(input int v, input logic [19:0] eb, input logic [4:0] en);
    int n = 0;
    c_in = 16'(v); c_valid = 1; step(); c_valid = 0;
    while (!c_ov && n < 50) begin step(); n++; end
    chk("c_latency", 64'(n), 64'(17));
    chk("c_bcd", 64'(c_bcd), 64'(eb));
    chk("c_nz", 64'(c_nz), 64'(en));
    c_ordy = 1; step(); c_ordy = 0;
  endtask
  initial begin
    logic [19:0] t;
    logic [4:0]  z;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    chk("rst_bcd", 64'(a_bcd), 64'(0));
    chk("rst_nz", 64'(a_nz), 64'(1));
    chk("rst_flags", 64'({a_ir, a_ov, a_busy}), 64'(3'b100));
    run_a(255, 12'h255, 3'b111);
    run_a(7, 12'h007, 3'b001);
    run_a(0, 12'h000, 3'b001);
    a_in = 8'd200; a_valid = 1; step(); a_in = 8'd99;
    for (int i = 0; i < 19; i++) begin
      a_valid = i[0];
      step();
      chk("bp_in_ready", 64'(a_ir), 64'(0));
      if (i >= 8) chk("bp_bcd_hold", 64'(a_bcd), 64'(12'h200));
    end
    a_valid = 0; a_ordy = 1; step(); a_ordy = 0;
    chk("bp_idle_ready", 64'(a_ir), 64'(1));
    chk("bp_bcd_after", 64'(a_bcd), 64'(12'h200));
    run_a(99, 12'h099, 3'b011);
    a_in = 8'd123; a_valid = 1; step(); a_valid = 0;
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_bcd", 64'(a_bcd), 64'(0));
    chk("arst_flags", 64'({a_ir, a_ov, a_busy}), 64'(3'b100));
    chk("arst_nz", 64'(a_nz), 64'(1));
    step(); rst_n = 1;
    run_a(45, 12'h045, 3'b011);
    for (int v = 0; v < 32; v++) begin
      t = to_bcd(longint'(v));
      z = nz_of(longint'(v));
      conv_b(v, t[7:0], z[1:0]);
    end
    conv_b(27, 8'h27, 2'b11);
    conv_b(31, 8'h31, 2'b11);
    conv_b(5, 8'h05, 2'b01);
    conv_c(65535, 20'h65535, 5'b11111);
    conv_c(1000, 20'h01000, 5'b01111);
    t = to_bcd(64'd40503);
    z = nz_of(64'd40503);
    conv_c(40503, t, z);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
